trap_ctrl: RTL

- Parametrised successor to the core's single-source trap sequencer (ecall only, trapping / trigger_trap / trigger_trap_ret).
- Arbitrates NUM_SRC trap sources (ecall, uart_IRQ, timer, ...) with per-source enable, level or edge sensitivity, and fixed priority.
- Captures cause and epc, and drives the one-cycle entry/return pulses consumed by Fetch and CSR.
- Sits beside CSR in the core top.

---
 rtl/trap_pkg.sv | 20 ++
 rtl/trap_ctrl_if.sv | 30 +++
 rtl/trap_prio_enc.sv | 24 ++
 rtl/trap_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared state encoding and cause constants for the trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2,
        EXIT   = 2'd3
    } trap_state_t;

    localparam int CAUSE_ECALL = 32'sd0;
    localparam int CAUSE_UART  = 32'sd1;
    localparam int CAUSE_TIMER = 32'sd2;

    // Index width for n items, never narrower than one bit.
    function automatic int cause_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Trap request / status bundle between the core (master) and trap_ctrl (slave).
interface trap_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
);
    localparam int CAUSE_W = trap_pkg::cause_width(NUM_SRC);

    logic [NUM_SRC-1:0] src_req;
    logic [NUM_SRC-1:0] src_en;
    logic               glb_en;
    logic               mem_hold;
    logic               trap_ret;
    logic [XLEN-1:0]    pc_in;
    logic               trapping;
    logic               trigger_trap;
    logic               trigger_trap_ret;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    epc;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output src_req, src_en, glb_en, mem_hold, trap_ret, pc_in,
        input  trapping, trigger_trap, trigger_trap_ret, cause, epc, pending
    );

    modport slave (
        input  src_req, src_en, glb_en, mem_hold, trap_ret, pc_in,
        output trapping, trigger_trap, trigger_trap_ret, cause, epc, pending
    );
endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module trap_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        index = {IDX_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end else begin
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Multi-source trap sequencer: arbitration, cause/epc capture, entry/return pulses.
// Optional nested preemption with a saved-context stack when TRAP_NEST_EN is defined.
module trap_ctrl #(
    parameter int                 NUM_SRC    = 4,
    parameter int                 XLEN       = 32,
    parameter logic [NUM_SRC-1:0] EDGE_MASK  = {NUM_SRC{1'b0}},
    parameter int                 NEST_DEPTH = 2
) (
    input  logic       clk,
    input  logic       Rst,
    trap_ctrl_if.slave bus
);
    import trap_pkg::*;

    localparam int CAUSE_W = cause_width(NUM_SRC);

    trap_state_t        state_r, state_nxt_s;
    logic [NUM_SRC-1:0] prev_req_r, edge_lat_r, edge_nxt_s, pending_s, clr_s;
    logic [CAUSE_W-1:0] cause_r, sel_idx_s, cause_top_s;
    logic [XLEN-1:0]    epc_r, epc_top_s;
    logic               sel_vld_s, idle_take_s, take_s, ret_s, pop_s, preempt_s, nest_ret_s;

    // Level sources follow the raw request; edge sources report their latch.
    assign pending_s   = ((bus.src_req & ~EDGE_MASK) | (edge_lat_r & EDGE_MASK)) & bus.src_en;
    assign clr_s       = take_s ? (NUM_SRC'(1'b1) << sel_idx_s) : {NUM_SRC{1'b0}};
    assign edge_nxt_s  = (edge_lat_r | (bus.src_req & ~prev_req_r & EDGE_MASK)) & ~clr_s;
    assign idle_take_s = (state_r == IDLE) && sel_vld_s && bus.glb_en && !bus.mem_hold;
    assign ret_s       = (state_r == ACTIVE) && bus.trap_ret;
    assign take_s      = idle_take_s | preempt_s;

    trap_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(CAUSE_W)) u_prio (
        .req   (pending_s),
        .valid (sel_vld_s),
        .index (sel_idx_s)
    );

`ifdef TRAP_NEST_EN
    localparam int SP_W = cause_width(NEST_DEPTH + 1);

    logic [SP_W-1:0]    sp_r;
    logic [CAUSE_W-1:0] cause_stk_r [NEST_DEPTH];
    logic [XLEN-1:0]    epc_stk_r   [NEST_DEPTH];
    logic               nest_ret_r;

    // A return is taken before a preemption that arrives in the same cycle.
    assign preempt_s   = (state_r == ACTIVE) && !bus.trap_ret && sel_vld_s && bus.glb_en &&
                         (sel_idx_s < cause_r) && (sp_r < SP_W'(NEST_DEPTH));
    assign pop_s       = ret_s && (sp_r != {SP_W{1'b0}});
    assign nest_ret_s  = nest_ret_r;
    assign cause_top_s = cause_stk_r[0];
    assign epc_top_s   = epc_stk_r[0];

    // Shift-register stack: entry 0 is always the most recently saved context.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sp_r       <= {SP_W{1'b0}};
            nest_ret_r <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                cause_stk_r[i] <= {CAUSE_W{1'b0}};
                epc_stk_r[i]   <= {XLEN{1'b0}};
            end
        end else begin
            if (ret_s) begin
                nest_ret_r <= pop_s;
            end else begin
                nest_ret_r <= nest_ret_r;
            end
            if (preempt_s) begin
                for (int i = NEST_DEPTH - 1; i > 0; i--) begin
                    cause_stk_r[i] <= cause_stk_r[i-1];
                    epc_stk_r[i]   <= epc_stk_r[i-1];
                end
                cause_stk_r[0] <= cause_r;
                epc_stk_r[0]   <= epc_r;
                sp_r           <= sp_r + SP_W'(1'b1);
            end else if (pop_s) begin
                for (int i = 0; i < NEST_DEPTH - 1; i++) begin
                    cause_stk_r[i] <= cause_stk_r[i+1];
                    epc_stk_r[i]   <= epc_stk_r[i+1];
                end
                sp_r <= sp_r - SP_W'(1'b1);
            end else begin
                sp_r <= sp_r;
            end
        end
    end
`else
    logic unused_nest_s;

    assign preempt_s     = 1'b0;
    assign pop_s         = 1'b0;
    assign nest_ret_s    = 1'b0;
    assign cause_top_s   = {CAUSE_W{1'b0}};
    assign epc_top_s     = {XLEN{1'b0}};
    assign unused_nest_s = ^NEST_DEPTH;
`endif

    // State register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; EXIT never evaluates entry, forcing an IDLE gap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (idle_take_s) state_nxt_s = ENTER; else state_nxt_s = IDLE;
            ENTER:   state_nxt_s = ACTIVE;
            ACTIVE:  if (ret_s) state_nxt_s = EXIT;
                     else if (preempt_s) state_nxt_s = ENTER;
                     else state_nxt_s = ACTIVE;
            EXIT:    if (nest_ret_s) state_nxt_s = ACTIVE; else state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from registered state and capture registers.
    always_comb begin
        bus.trigger_trap     = (state_r == ENTER);
        bus.trigger_trap_ret = (state_r == EXIT);
        bus.trapping         = (state_r == ENTER) || (state_r == ACTIVE) ||
                               ((state_r == EXIT) && nest_ret_s);
        bus.cause            = cause_r;
        bus.epc              = epc_r;
        bus.pending          = pending_s;
    end

    // Edge latches, request history and cause/epc capture.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            prev_req_r <= {NUM_SRC{1'b0}};
            edge_lat_r <= {NUM_SRC{1'b0}};
            cause_r    <= {CAUSE_W{1'b0}};
            epc_r      <= {XLEN{1'b0}};
        end else begin
            prev_req_r <= bus.src_req;
            edge_lat_r <= edge_nxt_s;
            if (take_s) begin
                cause_r <= sel_idx_s;
                epc_r   <= bus.pc_in;
            end else if (pop_s) begin
                cause_r <= cause_top_s;
                epc_r   <= epc_top_s;
            end else begin
                cause_r <= cause_r;
                epc_r   <= epc_r;
            end
        end
    end

endmodule
